paint_cmd_arbiter: RTL and testbench
====================================

# paint_cmd_arbiter

Command scheduler between the HID sources and the canvas memory of retro_paint. Accepts decoded Bluetooth commands (the bt_decoder `command_id`/`x_out`/`y_out`/`data_ready` outputs) and commands from the local keypad front-end. Arbitrates between them round-robin and executes one command at a time: MOVE updates the cursor, DRAW writes the current color to the canvas, PICKCOLOR reads a canvas pixel into the current color.

## Interface
Parameters:
- COORD_W, 6, width of each x/y coordinate (64x64 canvas)
- COLOR_W, 12, pixel/color width
- RESET_COLOR, 12'hFFF, value of cur_color after reset

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bt_ready  in  1  one-cycle pulse: bt_cmd/bt_x/bt_y valid; no backpressure
- bt_cmd  in  3  command id (1 MOVE, 2 DRAW, 3 PICKCOLOR)
- bt_x, bt_y  in  COORD_W each  coordinates
- kp_valid  in  1  keypad command valid; held until kp_ready
- kp_ready  out  1  keypad command accepted this cycle
- kp_cmd  in  3  same encoding as bt_cmd
- kp_x, kp_y  in  COORD_W each  coordinates
- mem_req  out  1  canvas access request, held until mem_ack
- mem_we  out  1  1 = write (DRAW), 0 = read (PICKCOLOR)
- mem_addr  out  2*COORD_W  {y, x}
- mem_wdata  out  COLOR_W  cur_color during DRAW
- mem_ack  in  1  access complete; read data valid the same cycle
- mem_rdata  in  COLOR_W  read data
- cursor_x, cursor_y  out  COORD_W each  cursor position
- cur_color  out  COLOR_W  active drawing color
- busy  out  1  FSM not in IDLE
- cmd_done  out  1  one-cycle pulse per completed valid command
- cmd_err  out  1  one-cycle pulse for a granted command with an id outside 1..3
- bt_overrun  out  1  one-cycle pulse when a BT command is lost

## Operation
- BT holding register (cmd, x, y, full flag). bt_ready loads it whenever it is empty or is being granted in the same cycle.
- If bt_ready arrives while the register is full and not being granted, the new command is dropped and bt_overrun pulses. The held command is kept.
- Arbitration happens only in IDLE. Requesters are bt_full and kp_valid.
- Round-robin pointer. After reset BT has priority. The pointer flips to the other source after every grant.
- A KP grant asserts kp_ready for that one cycle. kp_ready is 0 in every other cycle.
- The granted cmd/x/y are latched into exec registers. A BT grant clears bt_full.
- FSM states: IDLE, EXEC, MEM, DONE.
  - IDLE: on a grant, go to EXEC. Otherwise stay.
  - EXEC, MOVE: load cursor_x/cursor_y from exec x/y, then go to DONE.
  - EXEC, DRAW/PICK: go to MEM.
  - EXEC, other id: pulse cmd_err, no state change to cursor or color, then go to IDLE (no cmd_done).
  - MEM: mem_req=1; mem_we, mem_addr and mem_wdata are stable. On mem_ack:
    - DRAW: also loads the cursor with x/y.
    - PICKCOLOR: cur_color <= mem_rdata; the cursor is unchanged.
    - Then go to DONE.
  - DONE: cmd_done=1 for one cycle, then go to IDLE.
- No timeout in MEM; a missing ack stalls the block (busy stays 1).
- Reset values: FSM IDLE, bt_full=0, pointer=BT, cursor_x=cursor_y=0, cur_color=RESET_COLOR. All outputs are 0 except cur_color.
- Reset mid-operation clears everything asynchronously. mem_req drops immediately, and any pending or held command is discarded.

## Timing
- Grant in IDLE cycle N. EXEC at N+1.
- MOVE: cursor updates at the end of N+1; cmd_done at N+2. Next grant possible at N+3.
- DRAW/PICK: mem_req rises at N+2, the first MEM cycle. With ack in cycle M, mem_req is low at M+1, cmd_done is at M+1, and IDLE is at M+2.
- mem_ack is ignored outside MEM.
- Simultaneous bt_full and kp_valid: the pointer decides. The loser waits at least one full command.
- A BT pulse in the same cycle the held BT command is granted is accepted with no overrun.

## Test plan
- Reset, then BT MOVE (3'd1, x=45, y=37) -> cursor=(45,37) at N+1 end, cmd_done at N+2, mem_req never asserted.
- BT DRAW (2, 45, 37) with mem_ack after 3 wait cycles -> mem_req high 4 cycles, mem_we=1, mem_addr=12'h96D (y=37, x=45), mem_wdata=12'hFFF, cmd_done one cycle after ack.
- BT PICKCOLOR (3, 15, 4), mem_rdata=12'hA5C on ack -> mem_addr=12'h10F, mem_we=0, cur_color=12'hA5C, cursor unchanged.
- kp_valid held with MOVE(1,10,10) and a BT MOVE(1,20,20) pulse in the same cycle -> BT is granted first; after completion the KP command gets kp_ready for one cycle; final cursor=(10,10).
- During a stalled DRAW, two BT pulses -> first is held, second pulses bt_overrun; the held command executes after the DRAW.
- Command id 5 -> cmd_err pulse, no cmd_done, cursor/color unchanged. Then rst_n low during MEM -> mem_req drops asynchronously, cur_color returns to RESET_COLOR.

Source files
------------

// File: rtl/paint_cmd_arbiter.sv
// paint_cmd_arbiter
// Schedules paint commands from two sources onto the canvas memory, one at a
// time. Bluetooth commands arrive as single-cycle pulses and are caught in a
// one-deep holding register. Keypad commands use a valid/ready handshake.
// The two sources are served round-robin.
//
// Commands: MOVE (1) sets the cursor. DRAW (2) writes cur_color at (x,y) and
// moves the cursor there. PICKCOLOR (3) reads (x,y) into cur_color. Any other
// id is rejected with cmd_err.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   bt_ready, bt_cmd, bt_x, bt_y     BT command pulse (no backpressure)
//   kp_valid, kp_ready, kp_cmd,
//   kp_x, kp_y                       keypad command handshake
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata    canvas port; req held until ack
//   cursor_x, cursor_y, cur_color    drawing state
//   busy, cmd_done, cmd_err,
//   bt_overrun                       status pulses / level
module paint_cmd_arbiter #(
  parameter int                 COORD_W     = 6,
  parameter int                 COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] RESET_COLOR = 12'hFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bt_ready,
  input  logic [2:0]           bt_cmd,
  input  logic [COORD_W-1:0]   bt_x,
  input  logic [COORD_W-1:0]   bt_y,
  input  logic                 kp_valid,
  output logic                 kp_ready,
  input  logic [2:0]           kp_cmd,
  input  logic [COORD_W-1:0]   kp_x,
  input  logic [COORD_W-1:0]   kp_y,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [2*COORD_W-1:0] mem_addr,
  output logic [COLOR_W-1:0]   mem_wdata,
  input  logic                 mem_ack,
  input  logic [COLOR_W-1:0]   mem_rdata,
  output logic [COORD_W-1:0]   cursor_x,
  output logic [COORD_W-1:0]   cursor_y,
  output logic [COLOR_W-1:0]   cur_color,
  output logic                 busy,
  output logic                 cmd_done,
  output logic                 cmd_err,
  output logic                 bt_overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MEM, ST_DONE} state_t;

  localparam logic [2:0] CMD_MOVE = 3'd1;
  localparam logic [2:0] CMD_DRAW = 3'd2;
  localparam logic [2:0] CMD_PICK = 3'd3;
  localparam logic       PTR_BT   = 1'b0;
  localparam logic       PTR_KP   = 1'b1;

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic                 bt_full_q, bt_full_d;
  logic [2:0]           bt_cmd_q, bt_cmd_d;
  logic [COORD_W-1:0]   bt_x_q, bt_x_d, bt_y_q, bt_y_d;
  logic [2:0]           ex_cmd_q, ex_cmd_d;
  logic [COORD_W-1:0]   ex_x_q, ex_x_d, ex_y_q, ex_y_d;
  logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COLOR_W-1:0]   color_q, color_d;

  logic idle;
  logic grant_bt;
  logic grant_kp;

  // Arbitration is only live in IDLE. The pointer only matters when both
  // sources request; a lone requester always wins.
  assign idle     = (state_q == ST_IDLE);
  assign grant_bt = idle && bt_full_q && (!kp_valid || (ptr_q == PTR_BT));
  assign grant_kp = idle && kp_valid && (!bt_full_q || (ptr_q == PTR_KP));

  assign kp_ready   = grant_kp;
  // A pulse is lost only if the holding register stays occupied.
  assign bt_overrun = bt_ready && bt_full_q && !grant_bt;

  assign busy      = !idle;
  assign cmd_done  = (state_q == ST_DONE);
  assign mem_req   = (state_q == ST_MEM);
  assign mem_we    = mem_req && (ex_cmd_q == CMD_DRAW);
  assign mem_addr  = mem_req ? {ex_y_q, ex_x_q} : '0;
  assign mem_wdata = mem_we ? color_q : '0;
  assign cursor_x  = cur_x_q;
  assign cursor_y  = cur_y_q;
  assign cur_color = color_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    bt_full_d = bt_full_q;
    bt_cmd_d  = bt_cmd_q;
    bt_x_d    = bt_x_q;
    bt_y_d    = bt_y_q;
    ex_cmd_d  = ex_cmd_q;
    ex_x_d    = ex_x_q;
    ex_y_d    = ex_y_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    color_d   = color_q;
    cmd_err   = 1'b0;

    // The holding register can be refilled in the very cycle it is granted,
    // so a back-to-back pulse is not counted as an overrun.
    if (grant_bt) begin
      bt_full_d = 1'b0;
    end
    if (bt_ready && (!bt_full_q || grant_bt)) begin
      bt_full_d = 1'b1;
      bt_cmd_d  = bt_cmd;
      bt_x_d    = bt_x;
      bt_y_d    = bt_y;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_bt) begin
          ex_cmd_d = bt_cmd_q;
          ex_x_d   = bt_x_q;
          ex_y_d   = bt_y_q;
          ptr_d    = PTR_KP;
          state_d  = ST_EXEC;
        end else if (grant_kp) begin
          ex_cmd_d = kp_cmd;
          ex_x_d   = kp_x;
          ex_y_d   = kp_y;
          ptr_d    = PTR_BT;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (ex_cmd_q)
          CMD_MOVE: begin
            cur_x_d = ex_x_q;
            cur_y_d = ex_y_q;
            state_d = ST_DONE;
          end
          CMD_DRAW, CMD_PICK: state_d = ST_MEM;
          default: begin
            cmd_err = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (ex_cmd_q == CMD_DRAW) begin
            cur_x_d = ex_x_q;
            cur_y_d = ex_y_q;
          end else begin
            color_d = mem_rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_BT;
      bt_full_q <= 1'b0;
      bt_cmd_q  <= '0;
      bt_x_q    <= '0;
      bt_y_q    <= '0;
      ex_cmd_q  <= '0;
      ex_x_q    <= '0;
      ex_y_q    <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      color_q   <= RESET_COLOR;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      bt_full_q <= bt_full_d;
      bt_cmd_q  <= bt_cmd_d;
      bt_x_q    <= bt_x_d;
      bt_y_q    <= bt_y_d;
      ex_cmd_q  <= ex_cmd_d;
      ex_x_q    <= ex_x_d;
      ex_y_q    <= ex_y_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      color_q   <= color_d;
    end
  end

endmodule

// File: tb/tb_paint_cmd_arbiter.sv
// Self-checking bench for paint_cmd_arbiter. Stimulus queues the expected
// observable events (memory handshakes, done/err pulses, kp_ready, overrun);
// a negedge monitor pops and compares them as the DUT produces them.
module tb_paint_cmd_arbiter;

  localparam int K_MEM  = 0;
  localparam int K_ERR  = 1;
  localparam int K_DONE = 2;
  localparam int K_KPR  = 3;
  localparam int K_OVR  = 4;

  typedef struct {
    int          kind;
    logic [11:0] a;    // MEM: we    | DONE/ERR: cursor_x
    logic [11:0] b;    // MEM: addr  | DONE/ERR: cursor_y
    logic [11:0] c;    // MEM: wdata | DONE/ERR: cur_color
    int          len;  // MEM: req cycles (0=any) | DONE: 1=must follow ack
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bt_ready = 1'b0;
  logic [2:0]  bt_cmd = '0;
  logic [5:0]  bt_x = '0, bt_y = '0;
  logic        kp_valid = 1'b0;
  logic        kp_ready;
  logic [2:0]  kp_cmd = '0;
  logic [5:0]  kp_x = '0, kp_y = '0;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [11:0] mem_rdata = '0;
  logic [5:0]  cursor_x, cursor_y;
  logic [11:0] cur_color;
  logic        busy, cmd_done, cmd_err, bt_overrun;

  int   tests = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   req_run = 0;
  int   mem_req_cycles = 0;
  bit   prev_ack = 1'b0;
  bit   ack_en = 1'b1;
  int   ack_delay = 0;
  int   wait_cnt = 0;

  paint_cmd_arbiter #(.COORD_W(6), .COLOR_W(12), .RESET_COLOR(12'hFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .bt_ready(bt_ready), .bt_cmd(bt_cmd), .bt_x(bt_x), .bt_y(bt_y),
    .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_cmd(kp_cmd), .kp_x(kp_x), .kp_y(kp_y),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cur_color(cur_color),
    .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err), .bt_overrun(bt_overrun)
  );

  always #5 clk = ~clk;

  // Memory model: acks after ack_delay stalled cycles of mem_req.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (ack_en && wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  function automatic exp_t mk(input int k, input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input int len);
    exp_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c; e.len = len;
    return e;
  endfunction

  task automatic check_event(input int k, input string nm);
    exp_t e;
    bit   ok;
    tests++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: unexpected event, got %s required none at t=%0t", nm, nm, $time);
      return;
    end
    e = exp_q.pop_front();
    ok = (e.kind == k);
    if (ok) begin
      case (k)
        K_MEM: ok = (mem_we == e.a[0]) && (mem_addr == e.b) &&
                    (!e.a[0] || mem_wdata == e.c) && (e.len == 0 || req_run == e.len);
        K_DONE, K_ERR: ok = (cursor_x == e.a[5:0]) && (cursor_y == e.b[5:0]) &&
                            (cur_color == e.c) && (k == K_ERR || e.len == 0 || prev_ack);
        default: ok = 1'b1;
      endcase
    end
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s: got kind=%0d we=%0b addr=%h wdata=%h run=%0d cur=(%0d,%0d) color=%h prev_ack=%0b; required kind=%0d a=%h b=%h c=%h len=%0d t=%0t",
               nm, k, mem_we, mem_addr, mem_wdata, req_run, cursor_x, cursor_y, cur_color,
               prev_ack, e.kind, e.a, e.b, e.c, e.len, $time);
    end else begin
      $display("[TB] ok %s cur=(%0d,%0d) color=%h addr=%h t=%0t", nm, cursor_x, cursor_y,
               cur_color, mem_addr, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      req_run  = 0;
      prev_ack = 1'b0;
    end else begin
      if (mem_req) begin
        req_run++;
        mem_req_cycles++;
      end else begin
        req_run = 0;
      end
      if (mem_req && mem_ack) check_event(K_MEM, "mem_access");
      if (cmd_err)            check_event(K_ERR, "cmd_err");
      if (cmd_done)           check_event(K_DONE, "cmd_done");
      if (kp_ready)           check_event(K_KPR, "kp_ready");
      if (bt_overrun)         check_event(K_OVR, "bt_overrun");
      prev_ack = mem_req && mem_ack;
    end
  end

  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d t=%0t", nm, act, req, $time);
    end else begin
      $display("[TB] ok %s = %0d", nm, act);
    end
  endtask

  task automatic bt_send(input logic [2:0] c, input logic [5:0] x, input logic [5:0] y);
    @(posedge clk); #1;
    bt_cmd = c; bt_x = x; bt_y = y; bt_ready = 1'b1;
    @(posedge clk); #1;
    bt_ready = 1'b0;
  endtask

  task automatic kp_wait_release();
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (kp_ready) found = 1'b1;
    end
    if (!found) begin
      tests++; failures++;
      $display("[TB] FAIL kp_grant_timeout: got no kp_ready required kp_ready within 60 cycles");
    end
    @(posedge clk); #1;
    kp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 200 && quiet < 3; i++) begin
      @(negedge clk);
      if (!busy) quiet++; else quiet = 0;
    end
    if (quiet < 3) begin
      tests++; failures++;
      $display("[TB] FAIL idle_timeout: got busy=%0b required idle within 200 cycles", busy);
    end
  endtask

  initial begin
    int mrc0;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_mem_req", int'(mem_req), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_cursor", int'({cursor_y, cursor_x}), 0);
    check("reset_color", int'(cur_color), 12'hFFF);
    check("reset_pulses", int'({cmd_done, cmd_err, kp_ready, bt_overrun, mem_we}), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // BT MOVE with cycle-exact timing
    mrc0 = mem_req_cycles;
    exp_q.push_back(mk(K_DONE, 45, 37, 12'hFFF, 0));
    bt_send(3'd1, 6'd45, 6'd37);
    @(negedge clk); check("move_grant_busy", int'(busy), 0);
    @(negedge clk); check("move_exec_busy", int'(busy), 1);
    check("move_exec_no_done", int'(cmd_done), 0);
    check("move_exec_cursor_old", int'(cursor_x), 0);
    @(negedge clk); check("move_done_pulse", int'(cmd_done), 1);
    check("move_cursor_x", int'(cursor_x), 45);
    check("move_cursor_y", int'(cursor_y), 37);
    wait_idle();
    check("move_no_mem_req", mem_req_cycles - mrc0, 0);

    // BT DRAW, ack after 3 wait cycles
    ack_en = 1'b1; ack_delay = 3;
    exp_q.push_back(mk(K_MEM, 1, 12'h96D, 12'hFFF, 4));
    exp_q.push_back(mk(K_DONE, 45, 37, 12'hFFF, 1));
    bt_send(3'd2, 6'd45, 6'd37);
    wait_idle();

    // BT PICKCOLOR
    ack_delay = 1; mem_rdata = 12'hA5C;
    exp_q.push_back(mk(K_MEM, 0, 12'h10F, 12'h000, 2));
    exp_q.push_back(mk(K_DONE, 45, 37, 12'hA5C, 1));
    bt_send(3'd3, 6'd15, 6'd4);
    wait_idle();

    // KP then simultaneous KP/BT with pointer on BT
    exp_q.push_back(mk(K_KPR, 0, 0, 0, 0));
    exp_q.push_back(mk(K_DONE, 1, 1, 12'hA5C, 0));
    exp_q.push_back(mk(K_DONE, 20, 20, 12'hA5C, 0));
    exp_q.push_back(mk(K_KPR, 0, 0, 0, 0));
    exp_q.push_back(mk(K_DONE, 10, 10, 12'hA5C, 0));
    @(posedge clk); #1;
    kp_cmd = 3'd1; kp_x = 6'd1; kp_y = 6'd1; kp_valid = 1'b1;
    kp_wait_release();
    kp_cmd = 3'd1; kp_x = 6'd10; kp_y = 6'd10; kp_valid = 1'b1;
    bt_cmd = 3'd1; bt_x = 6'd20; bt_y = 6'd20; bt_ready = 1'b1;
    @(posedge clk); #1 bt_ready = 1'b0;
    kp_wait_release();
    wait_idle();
    check("rr_final_cursor_x", int'(cursor_x), 10);
    check("rr_final_cursor_y", int'(cursor_y), 10);

    // Stalled DRAW with a held BT command and an overrun
    ack_en = 1'b0; ack_delay = 0;
    exp_q.push_back(mk(K_OVR, 0, 0, 0, 0));
    exp_q.push_back(mk(K_MEM, 1, 12'h103, 12'hA5C, 0));
    exp_q.push_back(mk(K_DONE, 3, 4, 12'hA5C, 1));
    exp_q.push_back(mk(K_DONE, 7, 8, 12'hA5C, 0));
    bt_send(3'd2, 6'd3, 6'd4);
    repeat (5) @(negedge clk);
    check("stall_mem_req", int'(mem_req), 1);
    check("stall_busy", int'(busy), 1);
    bt_send(3'd1, 6'd7, 6'd8);
    bt_send(3'd1, 6'd9, 6'd9);
    repeat (3) @(negedge clk);
    ack_en = 1'b1;
    wait_idle();
    check("held_cmd_cursor_x", int'(cursor_x), 7);

    // Illegal id
    exp_q.push_back(mk(K_ERR, 7, 8, 12'hA5C, 0));
    bt_send(3'd5, 6'd30, 6'd30);
    wait_idle();
    check("err_cursor_kept", int'({cursor_y, cursor_x}), int'({6'd8, 6'd7}));
    check("err_color_kept", int'(cur_color), 12'hA5C);

    // Reset during MEM with a held command pending
    ack_en = 1'b0;
    bt_send(3'd2, 6'd1, 6'd2);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    check("rst_test_mem_req_seen", int'(seen), 1);
    bt_send(3'd1, 6'd50, 6'd50);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", int'(mem_req), 0);
    check("async_rst_color", int'(cur_color), 12'hFFF);
    check("async_rst_cursor", int'({cursor_y, cursor_x}), 0);
    check("async_rst_busy", int'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1; ack_en = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
